stream_demux_buffer: RTL and testbench
======================================

Name: stream_demux_buffer

Overview:
- Valid/ready stream demultiplexer. Takes one input stream with a destination index and steers each beat into one of NUM_ELEM per-output 2-entry buffers.
- Each output has its own valid/ready handshake, so one stalled consumer does not block the others.
- It is the distribution-side counterpart to the team's bitwise OR reduction combiner. It sits between a shared producer and several independent consumers.

Parameters:
- NUM_ELEM, 4, number of output streams (>=2).
- ELEM_WIDTH, 8, data width of each beat.
- SEL_WIDTH, $clog2(NUM_ELEM), width of the destination index (derived; do not override).

Ports:
- clk_i  input  1  clock; all logic is on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- data_i  input  ELEM_WIDTH  input beat data.
- sel_i  input  SEL_WIDTH  destination output index.
- valid_i  input  1  input beat valid.
- ready_o  output  1  input beat accepted when valid_i && ready_o.
- data_o  output  ELEM_WIDTH x NUM_ELEM (unpacked array)  head-of-buffer data per output.
- valid_o  output  NUM_ELEM  per-output head valid.
- ready_i  input  NUM_ELEM  per-output consumer ready.
- err_o  output  1  one-cycle pulse when an accepted beat has sel_i >= NUM_ELEM.

Behaviour:
- Clock and reset: one clock. Reset is synchronous, active-high, on clk_i/rst_i.
- Reset values:
  - all per-output counts 0; valid_o = 0; err_o = 0; data_o = 0.
  - ready_o follows its combinational rule, so it is 1 for any in-range sel_i after reset.
- Per-output buffer:
  - 2-entry FIFO: head and tail registers plus a 2-bit count (0, 1, 2).
  - Within one output, beats leave in acceptance order.
- ready_o:
  - Combinational from sel_i and the registered counts only. No path from ready_i or valid_i.
  - ready_o = 1 when sel_i >= NUM_ELEM (the beat is sunk).
  - Otherwise ready_o = (count[sel_i] != 2).
- Input fire (valid_i && ready_o, in range): the beat is written to buffer sel_i.
  - Visible on data_o[sel_i] with valid_o[sel_i] = 1 on the next cycle, i.e. latency is 1 cycle.
  - No bypass path from data_i to data_o.
- Output fire (valid_o[k] && ready_i[k]): the head is popped; the tail moves to head if count was 2.
- Simultaneous push and pop on the same output:
  - count 1: count stays 1 and the head takes the new beat.
  - count 2: cannot occur, because ready_o = 0.
  - Sustained push+pop at count 1 gives full throughput, one beat per cycle.
- Out-of-range sel_i (non-power-of-2 NUM_ELEM only): the beat is accepted and discarded, and err_o pulses high for exactly 1 cycle. No buffer state changes.
- valid_o[k] = (count[k] != 0). data_o[k] is held stable while valid_o[k] && !ready_i[k].
- ready_i[k] with valid_o[k] = 0 is ignored.
- Reset mid-operation: all buffered beats are dropped and valid_o clears on the cycle after rst_i is sampled high. Any input fire in that same cycle is ignored.
- Other outputs are unaffected by the push/pop activity of output k.

Optional Feature:
- Macro: STREAM_DEMUX_BUFFER_BROADCAST_EN.
- When defined:
  - Adds port broadcast_i (input, 1).
  - With broadcast_i = 1, sel_i is ignored and ready_o = 1 only if every count != 2.
  - On fire, the beat is written to all NUM_ELEM buffers in the same cycle.
  - Simultaneous pops on individual outputs proceed normally.
  - err_o never pulses for a broadcast beat.
- When undefined: the broadcast_i port and its logic are absent, and behaviour is exactly as above.

Test Plan:
- Reset, then send 0xA5 to sel=2 with ready_i = 0 -> next cycle valid_o = 4'b0100 and data_o[2] = 0xA5. A second beat 0x3C to sel=2 is accepted. A third beat to sel=2 sees ready_o = 0 and no other state changes.
- Output 2 full and stalled; send 0x11 to sel=0 -> ready_o = 1, accepted, and data_o[0] = 0x11 next cycle. Output 2 is unchanged.
- ready_i[1] held 1; send 0x01..0x08 to sel=1 back-to-back -> ready_o = 1 every cycle, and data_o[1] shows 0x01..0x08 on consecutive cycles, 1 cycle delayed.
- NUM_ELEM = 3, send sel=3 with data 0xFF -> ready_o = 1, err_o high for exactly 1 cycle, valid_o stays 0.
- Fill outputs 0 and 3 (count 2 and 1), then assert rst_i for 1 cycle while valid_i = 1 to sel=1 -> next cycle valid_o = 0. After reset the outputs accept 2 beats each again.
- With STREAM_DEMUX_BUFFER_BROADCAST_EN: broadcast 0x5A -> all valid_o bits = 1 and all data_o = 0x5A. With output 3 full, broadcast_i = 1 gives ready_o = 0 and no buffer is written.

Source files
------------

// File: rtl/stream_demux_buffer.sv
// Valid/ready demux: steers each input beat to one of NUM_ELEM 2-entry FIFOs.
// Ports: clk_i, rst_i, data_i/sel_i/valid_i/ready_o in; data_o/valid_o/ready_i out; err_o.
// Optional: STREAM_DEMUX_BUFFER_BROADCAST_EN adds broadcast_i (write to all).
module stream_demux_buffer #(
  parameter int NUM_ELEM   = 4,
  parameter int ELEM_WIDTH = 8,
  localparam int SEL_WIDTH = $clog2(NUM_ELEM)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ELEM_WIDTH-1:0] data_i,
  input  logic [SEL_WIDTH-1:0]  sel_i,
  input  logic                  valid_i,
`ifdef STREAM_DEMUX_BUFFER_BROADCAST_EN
  input  logic                  broadcast_i,
`endif
  output logic                  ready_o,
  output logic [ELEM_WIDTH-1:0] data_o [NUM_ELEM],
  output logic [NUM_ELEM-1:0]   valid_o,
  input  logic [NUM_ELEM-1:0]   ready_i,
  output logic                  err_o
);

  logic [ELEM_WIDTH-1:0] head [NUM_ELEM];
  logic [ELEM_WIDTH-1:0] tail [NUM_ELEM];
  logic [1:0]            cnt  [NUM_ELEM];
  logic [NUM_ELEM-1:0]   hit;
  logic [NUM_ELEM-1:0]   push;
  logic [NUM_ELEM-1:0]   pop;
  logic                  bcast;
  logic                  in_range;
  logic                  fire;

  // ready_o depends only on sel_i and counts; an unmatched sel
  // has no targets, so it always reads ready (beat is sunk).
  always_comb begin
    hit = '0;
    for (int k = 0; k < NUM_ELEM; k++)
      hit[k] = (sel_i == SEL_WIDTH'(k));
`ifdef STREAM_DEMUX_BUFFER_BROADCAST_EN
    bcast = broadcast_i;
`else
    bcast = 1'b0;
`endif
    in_range = |hit;
    ready_o  = 1'b1;
    for (int k = 0; k < NUM_ELEM; k++)
      if ((bcast || hit[k]) && cnt[k] == 2'd2)
        ready_o = 1'b0;
    fire = valid_i && ready_o;
    push = '0;
    pop  = '0;
    for (int k = 0; k < NUM_ELEM; k++) begin
      valid_o[k] = (cnt[k] != 2'd0);
      data_o[k]  = head[k];
      push[k]    = fire && (bcast || hit[k]);
      pop[k]     = valid_o[k] && ready_i[k];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
      for (int k = 0; k < NUM_ELEM; k++) begin
        head[k] <= '0;
        tail[k] <= '0;
        cnt[k]  <= 2'd0;
      end
    end else begin
      err_o <= fire && !in_range && !bcast;
      for (int k = 0; k < NUM_ELEM; k++) begin
        unique case (1'b1)
          // push+pop only happens at count 1: head is replaced
          (push[k] && pop[k]): head[k] <= data_i;
          (push[k] && !pop[k]): begin
            if (cnt[k] == 2'd0) head[k] <= data_i;
            else                tail[k] <= data_i;
            cnt[k] <= cnt[k] + 2'd1;
          end
          (!push[k] && pop[k]): begin
            head[k] <= tail[k];
            cnt[k]  <= cnt[k] - 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stream_demux_buffer.sv
// Directed bench for stream_demux_buffer (NUM_ELEM=4 and NUM_ELEM=3 instances).
module tb_stream_demux_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic [1:0] sel;
  logic       valid;
  logic       rdy_o;
  logic [7:0] dout [4];
  logic [3:0] vout;
  logic [3:0] rdy;
  logic       err;
  logic       bc;

  logic [7:0] data3;
  logic [1:0] sel3;
  logic       valid3;
  logic       rdy3_o;
  logic [7:0] dout3 [3];
  logic [2:0] vout3;
  logic [2:0] rdy3;
  logic       err3;

  int pass = 0;
  int total = 0;

  always #5 clk = ~clk;

  stream_demux_buffer #(.NUM_ELEM(4), .ELEM_WIDTH(8)) u4 (
    .clk_i(clk), .rst_i(rst), .data_i(data), .sel_i(sel),
    .valid_i(valid),
`ifdef STREAM_DEMUX_BUFFER_BROADCAST_EN
    .broadcast_i(bc),
`endif
    .ready_o(rdy_o), .data_o(dout), .valid_o(vout),
    .ready_i(rdy), .err_o(err));

  stream_demux_buffer #(.NUM_ELEM(3), .ELEM_WIDTH(8)) u3 (
    .clk_i(clk), .rst_i(rst), .data_i(data3), .sel_i(sel3),
    .valid_i(valid3),
`ifdef STREAM_DEMUX_BUFFER_BROADCAST_EN
    .broadcast_i(1'b0),
`endif
    .ready_o(rdy3_o), .data_o(dout3), .valid_o(vout3),
    .ready_i(rdy3), .err_o(err3));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0; valid3 = 1'b0;
    step(); step();
    rst = 1'b0; sel = 2'd2;
    #1;
    total++; if (vout !== 4'b0) $display("FAIL reset_valid got %b exp 0000", vout); else pass++;
    total++; if (err !== 1'b0) $display("FAIL reset_err got %b exp 0", err); else pass++;
    total++; if (rdy_o !== 1'b1) $display("FAIL reset_ready got %b exp 1", rdy_o); else pass++;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (dout[k] !== 8'h00) $display("FAIL reset_data%0d got %h exp 00", k, dout[k]);
      else pass++;
    end
    total++; if (vout3 !== 3'b0) $display("FAIL reset_valid3 got %b exp 000", vout3); else pass++;
  endtask

  task automatic test_fill();
    rdy = 4'b0; sel = 2'd2; data = 8'hA5; valid = 1'b1;
    #1;
    total++; if (rdy_o !== 1'b1) $display("FAIL fill_rdy0 got %b exp 1", rdy_o); else pass++;
    step();
    data = 8'h3C;
    #1;
    total++; if (vout !== 4'b0100) $display("FAIL fill_v1 got %b exp 0100", vout); else pass++;
    total++; if (dout[2] !== 8'hA5) $display("FAIL fill_d1 got %h exp a5", dout[2]); else pass++;
    total++; if (rdy_o !== 1'b1) $display("FAIL fill_rdy1 got %b exp 1", rdy_o); else pass++;
    step();
    data = 8'h77;
    #1;
    total++; if (rdy_o !== 1'b0) $display("FAIL fill_full got %b exp 0", rdy_o); else pass++;
    step();
    valid = 1'b0;
    #1;
    total++; if (vout !== 4'b0100) $display("FAIL fill_v3 got %b exp 0100", vout); else pass++;
    total++; if (dout[2] !== 8'hA5) $display("FAIL fill_d3 got %h exp a5", dout[2]); else pass++;
  endtask

  task automatic test_independent();
    sel = 2'd0; data = 8'h11; valid = 1'b1;
    #1;
    total++; if (rdy_o !== 1'b1) $display("FAIL indep_rdy got %b exp 1", rdy_o); else pass++;
    step();
    valid = 1'b0;
    #1;
    total++; if (vout !== 4'b0101) $display("FAIL indep_v got %b exp 0101", vout); else pass++;
    total++; if (dout[0] !== 8'h11) $display("FAIL indep_d0 got %h exp 11", dout[0]); else pass++;
    total++; if (dout[2] !== 8'hA5) $display("FAIL indep_d2 got %h exp a5", dout[2]); else pass++;
    rdy = 4'b0101;
    step();
    total++; if (vout !== 4'b0100) $display("FAIL drain_v1 got %b exp 0100", vout); else pass++;
    total++; if (dout[2] !== 8'h3C) $display("FAIL drain_d2 got %h exp 3c", dout[2]); else pass++;
    step();
    total++; if (vout !== 4'b0000) $display("FAIL drain_v2 got %b exp 0000", vout); else pass++;
    rdy = 4'b0;
  endtask

  task automatic test_back_to_back();
    rdy = 4'b0010; sel = 2'd1; valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      data = 8'(i);
      #1;
      total++; if (rdy_o !== 1'b1) $display("FAIL b2b_rdy%0d got %b exp 1", i, rdy_o); else pass++;
      step();
      total++;
      if (vout[1] !== 1'b1 || dout[1] !== 8'(i))
        $display("FAIL b2b_d%0d got %b/%h exp 1/%h", i, vout[1], dout[1], 8'(i));
      else pass++;
    end
    valid = 1'b0;
    step();
    total++; if (vout !== 4'b0) $display("FAIL b2b_end got %b exp 0000", vout); else pass++;
    rdy = 4'b0;
  endtask

  task automatic test_out_of_range();
    rdy3 = 3'b0; sel3 = 2'd3; data3 = 8'hFF; valid3 = 1'b1;
    #1;
    total++; if (rdy3_o !== 1'b1) $display("FAIL oor_rdy got %b exp 1", rdy3_o); else pass++;
    total++; if (err3 !== 1'b0) $display("FAIL oor_err0 got %b exp 0", err3); else pass++;
    step();
    valid3 = 1'b0;
    #1;
    total++; if (err3 !== 1'b1) $display("FAIL oor_err1 got %b exp 1", err3); else pass++;
    total++; if (vout3 !== 3'b0) $display("FAIL oor_v got %b exp 000", vout3); else pass++;
    step();
    total++; if (err3 !== 1'b0) $display("FAIL oor_err2 got %b exp 0", err3); else pass++;
  endtask

  task automatic test_reset_mid();
    rdy = 4'b0; valid = 1'b1;
    sel = 2'd0; data = 8'h21; step();
    data = 8'h22; step();
    sel = 2'd3; data = 8'h31; step();
    total++; if (vout !== 4'b1001) $display("FAIL mid_pre got %b exp 1001", vout); else pass++;
    rst = 1'b1; sel = 2'd1; data = 8'h99;
    step();
    rst = 1'b0; valid = 1'b0;
    #1;
    total++; if (vout !== 4'b0) $display("FAIL mid_v got %b exp 0000", vout); else pass++;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 2; j++) begin
        sel = 2'(k); data = 8'(16 * k + j); valid = 1'b1;
        #1;
        total++;
        if (rdy_o !== 1'b1) $display("FAIL mid_acc%0d_%0d got %b exp 1", k, j, rdy_o);
        else pass++;
        step();
      end
    end
    valid = 1'b0;
    #1;
    total++; if (vout !== 4'hF) $display("FAIL mid_vall got %b exp 1111", vout); else pass++;
    for (int k = 0; k < 4; k++) begin
      sel = 2'(k);
      #1;
      total++;
      if (rdy_o !== 1'b0) $display("FAIL mid_full%0d got %b exp 0", k, rdy_o);
      else pass++;
      total++;
      if (dout[k] !== 8'(16 * k)) $display("FAIL mid_head%0d got %h exp %h", k, dout[k], 8'(16 * k));
      else pass++;
    end
  endtask

`ifdef STREAM_DEMUX_BUFFER_BROADCAST_EN
  task automatic test_broadcast();
    rst = 1'b1; step(); rst = 1'b0;
    rdy = 4'b0; bc = 1'b1; sel = 2'd1; data = 8'h5A; valid = 1'b1;
    #1;
    total++; if (rdy_o !== 1'b1) $display("FAIL bc_rdy got %b exp 1", rdy_o); else pass++;
    step();
    bc = 1'b0; sel = 2'd3; data = 8'h44;
    #1;
    total++; if (vout !== 4'hF) $display("FAIL bc_v got %b exp 1111", vout); else pass++;
    total++; if (err !== 1'b0) $display("FAIL bc_err got %b exp 0", err); else pass++;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (dout[k] !== 8'h5A) $display("FAIL bc_d%0d got %h exp 5a", k, dout[k]);
      else pass++;
    end
    step();
    bc = 1'b1; sel = 2'd0; data = 8'h66;
    #1;
    total++; if (rdy_o !== 1'b0) $display("FAIL bc_full got %b exp 0", rdy_o); else pass++;
    step();
    valid = 1'b0; bc = 1'b0; rdy = 4'b0001;
    step();
    total++; if (vout !== 4'b1110) $display("FAIL bc_nowr got %b exp 1110", vout); else pass++;
    rdy = 4'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; data = '0; sel = '0; valid = 1'b0; rdy = '0; bc = 1'b0;
    data3 = '0; sel3 = '0; valid3 = 1'b0; rdy3 = '0;
    test_reset();
    test_fill();
    test_independent();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid();
`ifdef STREAM_DEMUX_BUFFER_BROADCAST_EN
    test_broadcast();
`endif
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
